// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: single-outstanding word bus with byte enables,
// pipeline stall, load extension and misalignment / bus-error / timeout faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_MISALIGN  = 2'd1,
    CAUSE_BUS_ERR   = 2'd2,
    CAUSE_TIMEOUT   = 2'd3
  } cause_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_write;
  logic [1:0]    addr_lo;
  logic [1:0]    size_q;
  logic          unsigned_q;

  logic          mem_req;
  logic          misaligned;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   shifted;
  logic [31:0]   load_fmt;
  logic          cnt_expired;

  assign mem_req     = req_valid & (mem_read | mem_write);
  assign stall       = ((state == S_IDLE) & mem_req) | (state == S_REQ) | (state == S_RESP);
  assign cnt_expired = (cnt == CNT_LAST);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = store_data;
    unique case (mem_size)
      2'd0: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'd1: begin
        misaligned = addr[0];
        be_c       = 4'b0011 << addr[1:0];
        wdata_c    = {2{store_data[15:0]}};
      end
      2'd2: misaligned = |addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Loads are formatted from the lane offset and size latched at request time.
  assign shifted = bus_rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_fmt = shifted;
    unique case (size_q)
      2'd0:    load_fmt = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_fmt = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_write    <= 1'b0;
      addr_lo     <= 2'b00;
      size_q      <= 2'b00;
      unsigned_q  <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      load_data   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (mem_req) begin
            op_write   <= mem_write;
            addr_lo    <= addr[1:0];
            size_q     <= mem_size;
            unsigned_q <= mem_unsigned;
            bus_we     <= mem_write;
            bus_addr   <= {addr[31:2], 2'b00};
            bus_be     <= be_c;
            bus_wdata  <= wdata_c;
            if (misaligned) begin
              state       <= S_DONE;
              done        <= 1'b1;
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
            end else begin
              state   <= S_REQ;
              bus_req <= 1'b1;
              cnt     <= '0;
            end
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            state   <= S_RESP;
            bus_req <= 1'b0;
            // Saturate so a grant on the last allowed cycle cannot wrap the budget.
            if (!cnt_expired) cnt <= cnt + 1'b1;
          end else if (cnt_expired) begin
            state       <= S_DONE;
            bus_req     <= 1'b0;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (bus_rvalid) begin
            state <= S_DONE;
            done  <= 1'b1;
            if (bus_err) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_BUS_ERR;
            end else begin
              fault       <= 1'b0;
              fault_cause <= CAUSE_NONE;
              if (!op_write) load_data <= load_fmt;
            end
          end else if (cnt_expired) begin
            state       <= S_DONE;
            done        <= 1'b1;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a delay-programmable bus responder plus
// a reference model whose expected completions are queued and popped on done.
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] addr, store_data;
  logic        stall, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .addr(addr), .store_data(store_data), .stall(stall), .done(done),
    .load_data(load_data), .fault(fault), .fault_cause(fault_cause),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Bus responder: grants gnt_delay cycles into a request, answers rv_delay
  // cycles after the grant. A negative gnt_delay never grants.
  logic        resp_gnt = 1'b0, resp_rvalid = 1'b0, resp_err = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        force_rvalid = 1'b0;
  logic [31:0] force_rdata = '0;
  int          gnt_delay = 0, rv_delay = 0, req_cnt = 0, resp_cnt = 0;
  bit          resp_pend = 1'b0;
  logic [31:0] rdata_v = '0;
  logic        err_v = 1'b0;

  assign bus_gnt    = resp_gnt;
  assign bus_rvalid = resp_rvalid | force_rvalid;
  assign bus_err    = resp_err;
  assign bus_rdata  = force_rvalid ? force_rdata : resp_rdata;

  always @(negedge clk) begin
    resp_gnt    = 1'b0;
    resp_rvalid = 1'b0;
    resp_err    = 1'b0;
    if (!rst_n) begin
      req_cnt   = 0;
      resp_cnt  = 0;
      resp_pend = 1'b0;
    end else begin
      if (resp_pend) begin
        if (resp_cnt == rv_delay) begin
          resp_rvalid = 1'b1;
          resp_err    = err_v;
          resp_rdata  = rdata_v;
          resp_pend   = 1'b0;
        end else resp_cnt++;
      end
      if (bus_req) begin
        if (req_cnt == gnt_delay) begin
          resp_gnt  = 1'b1;
          resp_pend = 1'b1;
          resp_cnt  = 0;
          req_cnt   = 0;
        end else req_cnt++;
      end else req_cnt = 0;
    end
  end

  typedef struct {
    logic [31:0] ld;
    logic        flt;
    logic [1:0]  cause;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_ld = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One access: model the result, queue it, drive the core inputs and follow
  // the DUT until done. from_idle enables cycle-0 stall and latency checks.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int gd, input int rvd, input logic [31:0] rdata,
                        input logic err, input bit from_idle,
                        output int done_at, output int req_cycles);
    logic        mis;
    int          lane, nb, exp_lat, k;
    logic [3:0]  m_be;
    logic [31:0] m_wd, val;
    logic [7:0]  b;
    logic [15:0] h;
    exp_t        e, got;
    bit          seen, stall_bad, unstable, have_done;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wd;
    logic [3:0]  cap_be;

    lane = int'(a[1:0]);
    nb   = 1 << size;
    mis  = (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'b00);
    for (int i = 0; i < 4; i++) m_be[i] = (i >= lane) && (i < lane + nb);
    if (size == 2'd2) m_be = 4'b1111;
    case (size)
      2'd0:    m_wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      2'd1:    m_wd = {sd[15:0], sd[15:0]};
      default: m_wd = sd;
    endcase
    val = rdata;
    if (!mis && size == 2'd0) begin
      b   = rdata[8*lane +: 8];
      val = uns ? {24'h0, b} : {{24{b[7]}}, b};
    end else if (!mis && size == 2'd1) begin
      h   = rdata[8*lane +: 16];
      val = uns ? {16'h0, h} : {{16{h[15]}}, h};
    end

    e.ld = model_ld; e.flt = 1'b0; e.cause = 2'd0;
    if (mis) begin
      e.flt = 1'b1; e.cause = 2'd1; exp_lat = 1;
    end else if (gd < 0) begin
      e.flt = 1'b1; e.cause = 2'd3; exp_lat = TO + 1;
    end else begin
      exp_lat = 3 + gd + rvd;
      if (err) begin
        e.flt = 1'b1; e.cause = 2'd2;
      end else if (!wr) begin
        model_ld = val;
        e.ld     = val;
      end
    end
    sb_q.push_back(e);

    gnt_delay = gd; rv_delay = rvd; rdata_v = rdata; err_v = err;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = size;
    mem_unsigned = uns; addr = a; store_data = sd;

    if (from_idle) begin
      #1;
      check({tag, " stall_c0"}, 32'(stall), 32'd1);
    end

    seen = 0; stall_bad = 0; unstable = 0; have_done = 0;
    req_cycles = 0; done_at = -1;
    cap_we = 0; cap_addr = '0; cap_wd = '0; cap_be = '0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus_req) begin
        req_cycles++;
        if (!seen) begin
          seen = 1;
          cap_we = bus_we; cap_addr = bus_addr; cap_be = bus_be; cap_wd = bus_wdata;
          check({tag, " bus_we"}, 32'(bus_we), 32'(wr));
          check({tag, " bus_addr"}, bus_addr, {a[31:2], 2'b00});
          check({tag, " bus_be"}, 32'(bus_be), 32'(m_be));
          if (wr) check({tag, " bus_wdata"}, bus_wdata, m_wd);
        end else if (bus_we !== cap_we || bus_addr !== cap_addr ||
                     bus_be !== cap_be || bus_wdata !== cap_wd) begin
          unstable = 1;
        end
      end
      if (done) begin
        have_done = 1;
        break;
      end
      if (!stall) stall_bad = 1;
    end

    if (!have_done) begin
      check({tag, " done_seen"}, 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      done_at = cyc;
      check({tag, " stall_at_done"}, 32'(stall), 32'd0);
      check({tag, " req_at_done"}, 32'(bus_req), 32'd0);
      check({tag, " stall_hold"}, 32'(stall_bad), 32'd0);
      if (from_idle) check({tag, " latency"}, 32'(k), 32'(exp_lat));
      if (seen) check({tag, " bus_stable"}, 32'(unstable), 32'd0);
      if (mis) check({tag, " no_bus_req"}, 32'(req_cycles), 32'd0);
      got = sb_q.pop_front();
      check({tag, " load_data"}, load_data, got.ld);
      check({tag, " fault"}, 32'(fault), 32'(got.flt));
      check({tag, " cause"}, 32'(fault_cause), 32'(got.cause));
    end
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, rc;
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    mem_size = 2'd0; mem_unsigned = 1'b0; addr = '0; store_data = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst stall", 32'(stall), 32'd0);
    check("rst load_data", load_data, 32'd0);
    check("rst fault", {29'd0, fault, fault_cause}, 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Non-memory instruction: no stall, no bus activity.
    @(negedge clk);
    req_valid = 1'b1;
    #1 check("nonmem stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("nonmem bus_req", 32'(bus_req), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);

    access("lb",  1, 0, 2'd0, 0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 0, 1, d1, rc);
    @(negedge clk);
    access("lbu", 1, 0, 2'd0, 1, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_1234, 0, 1, d1, rc);
    @(negedge clk);
    access("sh",  0, 1, 2'd1, 0, 32'h0000_2002, 32'hDEAD_BEEF, 0, 0, 32'h0, 0, 1, d1, rc);
    @(negedge clk);
    access("sb",  0, 1, 2'd0, 0, 32'h0000_2001, 32'hDEAD_BEEF, 1, 1, 32'h0, 0, 1, d1, rc);
    @(negedge clk);
    access("lw_mis", 1, 0, 2'd2, 0, 32'h0000_3002, 32'h0, 0, 0, 32'h0, 0, 1, d1, rc);
    @(negedge clk);
    access("lh_mis", 1, 0, 2'd1, 0, 32'h0000_3001, 32'h0, 0, 0, 32'h0, 0, 1, d1, rc);
    @(negedge clk);
    access("sz3_mis", 0, 1, 2'd3, 0, 32'h0000_3000, 32'h1, 0, 0, 32'h0, 0, 1, d1, rc);
    @(negedge clk);
    access("lh_wait", 1, 0, 2'd1, 0, 32'h0000_1002, 32'h0, 3, 2, 32'h8001_7FFF, 0, 1, d1, rc);
    @(negedge clk);
    check("lh_wait done_once", 32'(done), 32'd0);
    access("lh_err", 1, 0, 2'd1, 0, 32'h0000_1002, 32'h0, 3, 2, 32'h1234_5678, 1, 1, d1, rc);
    @(negedge clk);
    check("lh_err done_once", 32'(done), 32'd0);
    access("lhu", 1, 0, 2'd1, 1, 32'h0000_1000, 32'h0, 0, 1, 32'h0000_F00D, 0, 1, d1, rc);
    @(negedge clk);
    access("lw_to", 1, 0, 2'd2, 0, 32'h0000_4000, 32'h0, -1, 0, 32'h0, 0, 1, d1, rc);
    check("lw_to req_cycles", 32'(rc), 32'(TO));
    @(negedge clk);

    // Reset during RESP, then a stale response in IDLE must be ignored.
    gnt_delay = 0; rv_delay = 20;
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'd2;
    addr = 32'h0000_5000;
    repeat (2) @(negedge clk);
    check("rst_mid in_resp", {30'd0, stall, bus_req}, 32'd2);
    #2 rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0;
    #1;
    check("rst_mid bus_req", 32'(bus_req), 32'd0);
    check("rst_mid outs", {26'd0, done, fault, fault_cause, stall, bus_we}, 32'd0);
    check("rst_mid bus_addr", bus_addr, 32'd0);
    check("rst_mid load_data", load_data, 32'd0);
    model_ld = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    force_rdata = 32'hCAFE_F00D; force_rvalid = 1'b1;
    @(negedge clk);
    force_rvalid = 1'b0;
    check("stale done", 32'(done), 32'd0);
    check("stale load_data", load_data, 32'd0);
    @(negedge clk);
    check("stale done2", 32'(done), 32'd0);

    // Back-to-back words: second instruction presented during the first DONE.
    access("b2b_0", 1, 0, 2'd2, 0, 32'h0000_1008, 32'h0, 0, 0, 32'h1111_2222, 0, 1, d1, rc);
    access("b2b_1", 1, 0, 2'd2, 0, 32'h0000_100C, 32'h0, 0, 0, 32'h3333_4444, 0, 0, d2, rc);
    check("b2b spacing", 32'(d2 - d1), 32'd4);

    check("sb empty", 32'(sb_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit for the RV32I core. It consumes the decoded memory controls (`mem_read`, `mem_write`, `mem_size`, `mem_unsigned`) plus the effective address and store data. It drives a single-outstanding, word-addressed data bus with byte enables, stalls the pipeline until the access completes, and returns sign- or zero-extended load data. It also reports misaligned accesses, bus errors and bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 256: cycles allowed in REQ+RESP before a timeout fault; legal range ≥2.
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  memory-stage instruction valid; held with all core inputs stable while `stall`=1.
- `mem_read`  in  1  load request.
- `mem_write`  in  1  store request; wins if both are set.
- `mem_size`  in  2  0 byte, 1 half, 2 word, 3 reserved.
- `mem_unsigned`  in  1  zero-extend load (LBU/LHU).
- `addr`  in  32  effective byte address.
- `store_data`  in  32  rs2 value, right-aligned.
- `stall`  out  1  holds pipeline.
- `done`  out  1  one-cycle completion pulse.
- `load_data`  out  32  extended load result.
- `fault`  out  1  completion ended in fault; valid with `done`.
- `fault_cause`  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `bus_be`  out  4  byte enables.
- `bus_wdata`  out  32  lane-replicated write data.
- `bus_gnt`  in  1  request accepted this cycle.
- `bus_rvalid`  in  1  response (read data or write ack).
- `bus_err`  in  1  error qualifier, valid with `bus_rvalid`.
- `bus_rdata`  in  32  read data word.

## Operation
- **States and transitions**
  - IDLE: when `req_valid & (mem_read|mem_write)`, latch `op`, `addr[1:0]`, `size`, `unsigned`, bus address, `be` and `wdata`.
    - Misaligned access goes to DONE with cause 1; otherwise go to REQ.
  - REQ: `bus_req`=1. On `bus_gnt`, go to RESP.
  - RESP: wait for `bus_rvalid`, then go to DONE.
    - If `bus_err`=1, fault with cause 2.
    - Otherwise, for loads, register the formatted `load_data`.
  - DONE: `done`=1 and `stall`=0; go to IDLE unconditionally.
- **Stall**
  - `stall` = (IDLE & `req_valid` & (`mem_read`|`mem_write`)) | REQ | RESP. The IDLE term is combinational.
  - A non-memory `req_valid` never stalls and never touches the bus.
- **Alignment**
  - Byte: always aligned.
  - Half: requires `addr[0]`=0.
  - Word: requires `addr[1:0]`=0.
  - Size 3: always misaligned.
  - A misaligned access never asserts `bus_req`.
- **Store lanes**
  - Byte: `be` = 4'b0001<<`addr[1:0]`, `wdata` = `{4{sd[7:0]}}`.
  - Half: `be` = 4'b0011<<`addr[1:0]`, `wdata` = `{2{sd[15:0]}}`.
  - Word: `be` = 4'b1111, `wdata` = `sd`.
- **Loads**
  - `bus_be` is computed as for stores; `bus_we`=0.
  - Data is `bus_rdata >> (8*addr[1:0])`, then extended per size.
  - Byte and half are sign-extended unless `mem_unsigned`; word ignores `mem_unsigned`.
- **Stores**: `load_data` is unchanged.
- **Timeout**
  - The counter clears on entry to REQ and increments every REQ/RESP cycle that does not complete the access.
  - If it reaches `TIMEOUT_CYCLES`-1 with no `bus_gnt` (in REQ) or no `bus_rvalid` (in RESP) that cycle, go to DONE with cause 3.
  - The access is abandoned and `bus_req` drops.
- **Registered outputs**: `load_data`, `fault` and `fault_cause` are registered and hold until the next DONE.

## Timing
- **Reset**: state IDLE; `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `done`, `fault`, `fault_cause`, `load_data`, counter all 0. `stall` follows its equation.
- **Reset mid-access**: `bus_req` drops asynchronously. A stale `bus_rvalid` arriving in IDLE or REQ is ignored.
- **Bus handshake**: `bus_req`/`bus_we`/`bus_addr`/`bus_be`/`bus_wdata` are registered and stable from REQ entry until the `bus_gnt` cycle. `bus_rvalid` is accepted only in RESP, earliest one cycle after `bus_gnt`.
- **Minimum latency**
  - Aligned access, zero-wait bus (gnt in first REQ cycle, rvalid in first RESP cycle): request seen cycle 0, `done` cycle 3, `stall` high cycles 0–2.
  - Misaligned: `done` cycle 1.
- **DONE cycle**: the core advances at the edge ending DONE. The following IDLE cycle evaluates the next instruction, giving back-to-back accesses with no idle bubble beyond DONE.

## Test plan
- **Aligned load**: LB `addr`=0x1003, `bus_rdata`=0x80FF_1234, zero-wait bus.
  - `bus_addr`=0x1000, `be`=4'b1000, `done` at cycle 3, `load_data`=0xFFFF_FF80.
  - Repeat as LBU → 0x0000_0080.
- **Store lanes**
  - SH `addr`=0x2002, `store_data`=0xDEAD_BEEF → `bus_we`=1, `be`=4'b1100, `wdata`=0xBEEF_BEEF.
  - SB `addr`=0x2001 → `be`=4'b0010, `wdata`=0xEFEF_EFEF.
- **Misaligned**: LW `addr`=0x3002 and LH `addr`=0x3001 each produce no `bus_req`, `done` at cycle 1, `fault`=1, `fault_cause`=1.
- **Wait states and bus error**
  - `bus_gnt` delayed 3 cycles, `bus_rvalid` 2 more: `stall` high throughout, bus outputs stable, `done` exactly once.
  - Rerun with `bus_err`=1 → `fault_cause`=2, `load_data` unchanged.
- **Timeout**: `TIMEOUT_CYCLES`=8, `bus_gnt` never asserted → `bus_req` high 8 cycles, then `done`, `fault_cause`=3, `bus_req`=0.
- **Reset and back-to-back**
  - Assert `rst_n`=0 in RESP: outputs zero immediately; a late `bus_rvalid` is ignored.
  - After reset, two consecutive LWs complete with `done` pulses 4 cycles apart.
